// File: rtl/ram_arbiter_if.sv
// Request/response bundle between one RAM requester and ram_arbiter.
// The requester uses the master modport and the arbiter uses the slave modport.
interface ram_arbiter_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  hb;
    logic        uload;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output valid, addr, wdata, we, hb, uload,
        input  ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  valid, addr, wdata, we, hb, uload,
        output ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one data RAM between two requesters: IDLE -> ACCESS -> RESP, with bad requests going IDLE -> RESP.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (port 0 first) otherwise.
module ram_arbiter #(
    parameter int RAM_BYTES = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    ram_arbiter_if.slave       m0,
    ram_arbiter_if.slave       m1,
    output logic [31:0]        ram_addr_o,
    output logic [31:0]        ram_wdata_o,
    output logic               ram_we_o,
    output logic [1:0]         ram_hb_o,
    output logic               ram_uload_o,
    input  logic [31:0]        ram_rdata_i,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q;
    logic        port_q;
    logic [31:0] ram_addr_q;
    logic [31:0] ram_wdata_q;
    logic        ram_we_q;
    logic [1:0]  ram_hb_q;
    logic        ram_uload_q;

    logic [1:0]  req_valid;
    logic        any_valid;
    logic        grant_d;
    logic        accept_d;
    logic        err_d;
    logic        resp_fire_d;
    logic        resp_port_d;
    logic [31:0] resp_rdata_d;
    logic        resp_err_d;

    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_we;
    logic [1:0]  sel_hb;
    logic        sel_uload;

    logic [1:0]  rsp_valid_q;
    logic [1:0]  rsp_err_q;
    logic [31:0] rsp_rdata_q [2];

    assign req_valid = {m1.valid, m0.valid};
    assign any_valid = |req_valid;

`ifdef ARB_ROUND_ROBIN_EN
    // Holds the port granted most recently; the other port wins a tie.
    logic last_grant_q;

    always_comb begin
        if (req_valid == 2'b11) begin
            grant_d = ~last_grant_q;
        end else begin
            grant_d = ~req_valid[0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= 1'b1;
        end else if (accept_d) begin
            last_grant_q <= grant_d;
        end
    end
`else
    assign grant_d = ~req_valid[0];
`endif

    // Ready is combinational so that a requester dropping valid is never latched.
    assign accept_d = (state_q == IDLE) && any_valid && !rst_i;
    assign m0.ready = accept_d && (grant_d == 1'b0);
    assign m1.ready = accept_d && (grant_d == 1'b1);

    assign sel_addr  = grant_d ? m1.addr  : m0.addr;
    assign sel_wdata = grant_d ? m1.wdata : m0.wdata;
    assign sel_we    = grant_d ? m1.we    : m0.we;
    assign sel_hb    = grant_d ? m1.hb    : m0.hb;
    assign sel_uload = grant_d ? m1.uload : m0.uload;

    always_comb begin
        err_d = 1'b0;
        if (sel_hb == 2'b11) begin
            err_d = 1'b1;
        end
        if ((sel_hb == 2'b01) && sel_addr[0]) begin
            err_d = 1'b1;
        end
        if ((sel_hb == 2'b10) && (sel_addr[1:0] != 2'b00)) begin
            err_d = 1'b1;
        end
        if (sel_addr >= 32'(RAM_BYTES)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            port_q      <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_hb_q    <= '0;
            ram_uload_q <= 1'b0;
        end else begin
            ram_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        port_q <= grant_d;
                        if (err_d) begin
                            state_q <= RESP;
                        end else begin
                            state_q     <= ACCESS;
                            ram_addr_q  <= sel_addr;
                            ram_wdata_q <= sel_wdata;
                            ram_we_q    <= sel_we;
                            ram_hb_q    <= sel_hb;
                            ram_uload_q <= sel_uload;
                        end
                    end
                end
                ACCESS:  state_q <= RESP;
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // A response is loaded on the edge that enters RESP, so rsp_valid coincides with RESP.
    always_comb begin
        resp_fire_d  = 1'b0;
        resp_port_d  = port_q;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        if (state_q == IDLE) begin
            resp_fire_d = accept_d && err_d;
            resp_port_d = grant_d;
            resp_err_d  = 1'b1;
        end else if (state_q == ACCESS) begin
            resp_fire_d  = 1'b1;
            resp_rdata_d = ram_we_q ? 32'h0 : ram_rdata_i;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rsp_valid_q[gi] <= 1'b0;
                rsp_err_q[gi]   <= 1'b0;
                rsp_rdata_q[gi] <= '0;
            end else if (resp_fire_d && (resp_port_d == 1'(gi))) begin
                rsp_valid_q[gi] <= 1'b1;
                rsp_err_q[gi]   <= resp_err_d;
                rsp_rdata_q[gi] <= resp_rdata_d;
            end else begin
                rsp_valid_q[gi] <= 1'b0;
                rsp_err_q[gi]   <= 1'b0;
                rsp_rdata_q[gi] <= '0;
            end
        end
    end

    assign m0.rsp_valid = rsp_valid_q[0];
    assign m0.rsp_err   = rsp_err_q[0];
    assign m0.rsp_rdata = rsp_rdata_q[0];
    assign m1.rsp_valid = rsp_valid_q[1];
    assign m1.rsp_err   = rsp_err_q[1];
    assign m1.rsp_rdata = rsp_rdata_q[1];

    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign ram_we_o    = ram_we_q;
    assign ram_hb_o    = ram_hb_q;
    assign ram_uload_o = ram_uload_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a byte-addressed RAM model behind it.
// Build with ARB_ROUND_ROBIN_EN defined to check the round-robin grant order.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [1:0]  ram_hb;
    logic        ram_uload;
    logic [31:0] ram_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:1023];
    bit         mem_clear;
    logic [9:0] ridx;
    logic [7:0] rb0, rb1, rb2, rb3;

    ram_arbiter_if m0_if ();
    ram_arbiter_if m1_if ();

    ram_arbiter #(.RAM_BYTES(1024)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .m0          (m0_if),
        .m1          (m1_if),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_we_o    (ram_we),
        .ram_hb_o    (ram_hb),
        .ram_uload_o (ram_uload),
        .ram_rdata_i (ram_rdata),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // RAM model: little-endian bytes, write at the clock edge, combinational read with extension.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end else if (ram_we) begin
            mem[ram_addr[9:0]] <= ram_wdata[7:0];
            if (ram_hb != 2'b00) mem[ram_addr[9:0] + 10'd1] <= ram_wdata[15:8];
            if (ram_hb == 2'b10) begin
                mem[ram_addr[9:0] + 10'd2] <= ram_wdata[23:16];
                mem[ram_addr[9:0] + 10'd3] <= ram_wdata[31:24];
            end
        end
    end

    always_comb begin
        ridx = ram_addr[9:0];
        rb0  = mem[ridx];
        rb1  = mem[ridx + 10'd1];
        rb2  = mem[ridx + 10'd2];
        rb3  = mem[ridx + 10'd3];
        case (ram_hb)
            2'b00:   ram_rdata = {{24{~ram_uload & rb0[7]}}, rb0};
            2'b01:   ram_rdata = {{16{~ram_uload & rb1[7]}}, rb1, rb0};
            default: ram_rdata = {rb3, rb2, rb1, rb0};
        endcase
    end

    function automatic logic [31:0] mem_word(input int a);
        return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
    endfunction

    task automatic drive_port(input int p, input bit v, input logic [31:0] a, input logic [31:0] wd,
                              input bit we, input logic [1:0] hb, input bit ul);
        if (p == 0) begin
            m0_if.valid = v; m0_if.addr = a; m0_if.wdata = wd;
            m0_if.we = we; m0_if.hb = hb; m0_if.uload = ul;
        end else begin
            m1_if.valid = v; m1_if.addr = a; m1_if.wdata = wd;
            m1_if.we = we; m1_if.hb = hb; m1_if.uload = ul;
        end
    endtask

    // Issues one request and reports what came back; lat counts cycles from the ready cycle.
    task automatic issue(input int p, input logic [31:0] a, input logic [31:0] wd, input bit we,
                         input logic [1:0] hb, input bit ul,
                         output int lat, output logic [31:0] rd, output logic er,
                         output bit wrong_port, output bit we_seen);
        bit got;
        lat = -1; rd = 'x; er = 1'bx; wrong_port = 0; we_seen = 0; got = 0;
        @(negedge clk);
        drive_port(p, 1'b1, a, wd, we, hb, ul);
        for (int n = 0; n < 20; n++) begin
            #1;
            if ((p == 0) ? m0_if.ready : m1_if.ready) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        drive_port(p, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
        if (got) begin
            for (int c = 1; c < 10; c++) begin
                if (ram_we) we_seen = 1;
                if ((p == 0) ? m1_if.rsp_valid : m0_if.rsp_valid) wrong_port = 1;
                if ((p == 0) ? m0_if.rsp_valid : m1_if.rsp_valid) begin
                    lat = c;
                    rd  = (p == 0) ? m0_if.rsp_rdata : m1_if.rsp_rdata;
                    er  = (p == 0) ? m0_if.rsp_err : m1_if.rsp_err;
                    break;
                end
                @(negedge clk);
            end
        end
        $display("txn port=%0d addr=%08h we=%0d hb=%02b ul=%0d -> lat=%0d rdata=%08h err=%0b",
                 p, a, we, hb, ul, lat, rd, er);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        mem_clear = 1'b1;
        drive_port(0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
        drive_port(1, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
        repeat (3) @(negedge clk);
        m0_if.valid = 1'b1;
        #1;
        checks++; if (m0_if.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", m0_if.ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", ram_we); end
        checks++; if ({ram_addr, ram_wdata, ram_hb, ram_uload} !== 67'h0) begin
            errors++; $display("FAIL reset_ram_bus got addr=%08h wdata=%08h hb=%b ul=%b exp=0", ram_addr, ram_wdata, ram_hb, ram_uload); end
        checks++; if ({m0_if.rsp_valid, m1_if.rsp_valid, m0_if.rsp_err, m1_if.rsp_err} !== 4'b0) begin
            errors++; $display("FAIL reset_rsp got=%b exp=0000", {m0_if.rsp_valid, m1_if.rsp_valid, m0_if.rsp_err, m1_if.rsp_err}); end
        checks++; if ({m0_if.rsp_rdata, m1_if.rsp_rdata} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata got=%08h/%08h exp=0", m0_if.rsp_rdata, m1_if.rsp_rdata); end
        @(negedge clk);
        m0_if.valid = 1'b0;
        rst_i = 1'b0;
        mem_clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word_store_load();
        int lat; logic [31:0] rd; logic er; bit wp, ws;
        issue(0, 32'h10, 32'hDEADBEEF, 1'b1, 2'b10, 1'b0, lat, rd, er, wp, ws);
        checks++; if (lat !== 2) begin errors++; $display("FAIL store_latency got=%0d exp=2", lat); end
        checks++; if ({er, rd} !== 33'h0) begin errors++; $display("FAIL store_rsp got err=%b rdata=%08h exp err=0 rdata=0", er, rd); end
        checks++; if (ws !== 1'b1) begin errors++; $display("FAIL store_we got=%b exp=1", ws); end
        checks++; if (mem_word(32'h10) !== 32'hDEADBEEF) begin errors++; $display("FAIL store_mem got=%08h exp=deadbeef", mem_word(32'h10)); end
        issue(0, 32'h10, 32'h0, 1'b0, 2'b10, 1'b0, lat, rd, er, wp, ws);
        checks++; if (lat !== 2) begin errors++; $display("FAIL load_latency got=%0d exp=2", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata got=%08h exp=deadbeef", rd); end
        checks++; if ({er, wp, ws} !== 3'b000) begin errors++; $display("FAIL load_flags got err/wrongport/we=%b exp=000", {er, wp, ws}); end
    endtask

    task automatic test_subword();
        int lat; logic [31:0] rd; logic er; bit wp, ws;
        issue(1, 32'h20, 32'h000080FF, 1'b1, 2'b10, 1'b0, lat, rd, er, wp, ws);
        checks++; if (mem_word(32'h20) !== 32'h000080FF) begin errors++; $display("FAIL sub_store_mem got=%08h exp=000080ff", mem_word(32'h20)); end
        issue(0, 32'h21, 32'h0, 1'b0, 2'b00, 1'b0, lat, rd, er, wp, ws);
        checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL sbyte_rdata got=%08h exp=ffffff80", rd); end
        checks++; if ({lat == 2, er} !== 2'b10) begin errors++; $display("FAIL sbyte_timing got lat=%0d err=%b exp lat=2 err=0", lat, er); end
        issue(0, 32'h20, 32'h0, 1'b0, 2'b01, 1'b1, lat, rd, er, wp, ws);
        checks++; if (rd !== 32'h000080FF) begin errors++; $display("FAIL uhalf_rdata got=%08h exp=000080ff", rd); end
        issue(1, 32'h20, 32'h0, 1'b0, 2'b01, 1'b0, lat, rd, er, wp, ws);
        checks++; if (rd !== 32'hFFFF80FF) begin errors++; $display("FAIL shalf_rdata got=%08h exp=ffff80ff", rd); end
        issue(1, 32'h20, 32'h0, 1'b0, 2'b00, 1'b1, lat, rd, er, wp, ws);
        checks++; if (rd !== 32'h000000FF) begin errors++; $display("FAIL ubyte_rdata got=%08h exp=000000ff", rd); end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic er; bit wp, ws;
        logic [31:0] ea  [4] = '{32'h3, 32'h2, 32'h20, 32'h400};
        logic [1:0]  ehb [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
        bit          ewe [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            issue(i % 2, ea[i], 32'h12345678, ewe[i], ehb[i], 1'b0, lat, rd, er, wp, ws);
            checks++; if (lat !== 1) begin errors++; $display("FAIL err%0d_latency got=%0d exp=1", i, lat); end
            checks++; if (er !== 1'b1) begin errors++; $display("FAIL err%0d_flag got=%b exp=1", i, er); end
            checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err%0d_rdata got=%08h exp=0", i, rd); end
            checks++; if ({ws, wp} !== 2'b00) begin errors++; $display("FAIL err%0d_ram_we got we/wrongport=%b exp=00", i, {ws, wp}); end
        end
        checks++; if ({mem_word(0), mem_word(4)} !== 64'h0) begin
            errors++; $display("FAIL err_mem_low got=%08h_%08h exp=0", mem_word(4), mem_word(0)); end
        checks++; if (mem_word(32'h20) !== 32'h000080FF) begin errors++; $display("FAIL err_mem_20 got=%08h exp=000080ff", mem_word(32'h20)); end
    endtask

    task automatic test_simultaneous();
        int grants [4];
        int gcyc   [4];
        int rports [4];
        logic [31:0] rdat [4];
        int exp_g  [4];
        int ng = 0, nr = 0, bad_ready = 0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        @(negedge clk);
        drive_port(0, 1'b1, 32'h10, 32'h0, 1'b0, 2'b10, 1'b0);
        drive_port(1, 1'b1, 32'h20, 32'h0, 1'b0, 2'b10, 1'b0);
        for (int c = 0; c < 40 && nr < 4; c++) begin
            #1;
            if ((m0_if.ready || m1_if.ready) && busy) bad_ready++;
            if (m0_if.ready && m1_if.ready) bad_ready++;
            if ((m0_if.ready || m1_if.ready) && ng < 4) begin
                grants[ng] = m1_if.ready ? 1 : 0;
                gcyc[ng] = c;
                ng++;
            end
            if ((m0_if.rsp_valid || m1_if.rsp_valid) && nr < 4) begin
                rports[nr] = (m0_if.rsp_valid && m1_if.rsp_valid) ? 2 : (m1_if.rsp_valid ? 1 : 0);
                rdat[nr] = m1_if.rsp_valid ? m1_if.rsp_rdata : m0_if.rsp_rdata;
                nr++;
            end
            @(negedge clk);
        end
        drive_port(0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
        drive_port(1, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
        $display("txn simultaneous grants=%0d responses=%0d", ng, nr);
        checks++; if (nr !== 4) begin errors++; $display("FAIL sim_count got=%0d responses exp=4", nr); end
        checks++; if (bad_ready !== 0) begin errors++; $display("FAIL sim_ready_busy got=%0d exp=0", bad_ready); end
        for (int i = 0; i < nr; i++) begin
            checks++; if (grants[i] !== exp_g[i]) begin errors++; $display("FAIL sim_grant%0d got=%0d exp=%0d", i, grants[i], exp_g[i]); end
            checks++; if (rports[i] !== exp_g[i]) begin errors++; $display("FAIL sim_rsp_port%0d got=%0d exp=%0d", i, rports[i], exp_g[i]); end
            checks++; if (rdat[i] !== ((exp_g[i] == 0) ? 32'hDEADBEEF : 32'h000080FF)) begin
                errors++; $display("FAIL sim_rdata%0d got=%08h exp port %0d data", i, rdat[i], exp_g[i]); end
            if (i > 0) begin
                checks++; if (gcyc[i] - gcyc[i-1] !== 3) begin errors++; $display("FAIL sim_spacing%0d got=%0d exp=3", i, gcyc[i] - gcyc[i-1]); end
            end
        end
    endtask

    task automatic test_reset_in_access();
        int lat; logic [31:0] rd; logic er; bit wp, ws;
        bit got = 0;
        int stray = 0;
        @(negedge clk);
        drive_port(1, 1'b1, 32'h10, 32'h0, 1'b0, 2'b10, 1'b0);
        for (int n = 0; n < 20; n++) begin
            #1;
            if (m1_if.ready) begin got = 1; break; end
            @(negedge clk);
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL rst_acc_accept got=%b exp=1", got); end
        @(negedge clk);
        drive_port(1, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_acc_in_access got busy=%b exp=1", busy); end
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        checks++; if ({busy, ram_we} !== 2'b00) begin errors++; $display("FAIL rst_acc_idle got busy/we=%b exp=00", {busy, ram_we}); end
        for (int c = 0; c < 4; c++) begin
            if (m1_if.rsp_valid || m0_if.rsp_valid) stray++;
            @(negedge clk);
        end
        $display("txn reset during ACCESS, stray responses=%0d", stray);
        checks++; if (stray !== 0) begin errors++; $display("FAIL rst_acc_rsp got=%0d responses exp=0", stray); end
        issue(1, 32'h10, 32'h0, 1'b0, 2'b10, 1'b0, lat, rd, er, wp, ws);
        checks++; if ({lat == 2, er, rd} !== {2'b10, 32'hDEADBEEF}) begin
            errors++; $display("FAIL rst_acc_after got lat=%0d err=%b rdata=%08h exp lat=2 err=0 rdata=deadbeef", lat, er, rd); end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_subword();
        test_errors();
        test_simultaneous();
        test_reset_in_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
